chi_inv: RTL and testbench
==========================

CHI_INV -- requirements
Module: chi_inv

Interface
REQ-001 SHALL have parameter STATE_SIZE, default 1600, meaning the Keccak-f state width in bits.
REQ-002 SHALL have parameter Z_WIDTH, default 64, meaning the lane length in bits.
REQ-003 SHALL have parameter ROW_SIZE, default 5, meaning the row length and lanes per plane.
REQ-004 SHALL have port CLK  input  1  clock; single clock, all logic on its rising edge.
REQ-005 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-006 SHALL have port IN  input  [0:STATE_SIZE-1]  state to invert; bit index = y*320 + x*64 + z.
REQ-007 SHALL have port IN_VALID  input  1  IN holds a valid state.
REQ-008 SHALL have port IN_READY  output  1  block accepts IN this cycle.
REQ-009 SHALL have port OUT  output  [0:STATE_SIZE-1]  inverse-chi result, same bit ordering as IN.
REQ-010 SHALL have port OUT_VALID  output  1  OUT holds a valid result.
REQ-011 SHALL have port OUT_READY  input  1  consumer takes OUT this cycle.

Function
REQ-012 SHALL compute OUT such that chi(OUT) == IN, where chi per row is b[x] = a[x] ^ (~a[x+1 mod 5] & a[x+2 mod 5]).
REQ-013 SHALL define a row as the 5 bits x=0..4 sharing the same y and z; the 320 rows are independent.
REQ-014 SHALL use a FSM with states IDLE, BUSY, DONE.
REQ-015 SHALL assert IN_READY only when the state is IDLE and RST is low.
REQ-016 SHALL, on IN_VALID && IN_READY, load IN into the internal state register, clear the plane counter to 0, and enter BUSY.
REQ-017 SHALL, in BUSY, replace the 64 rows of plane y = counter with their inverses each cycle, then increment the counter.
REQ-018 SHALL go to DONE on the cycle plane 4 is written; handshake at edge t gives OUT_VALID high from edge t+5.
REQ-019 SHALL drive OUT from the state register and assert OUT_VALID only in DONE.
REQ-020 SHALL hold OUT and OUT_VALID stable in DONE while OUT_READY is low.
REQ-021 SHALL return to IDLE on OUT_VALID && OUT_READY; IN_READY rises the following cycle (no same-cycle re-accept).
REQ-022 SHALL ignore IN and IN_VALID while in BUSY or DONE.
REQ-023 SHALL keep the plane counter 3 bits wide, range 0..4, never wrapping past 4.

Reset
REQ-024 SHALL, with RST high at a clock edge, set state IDLE, counter 0, state register all zeros, OUT_VALID 0.
REQ-025 SHALL abort an in-flight BUSY or DONE operation on RST and discard its data, producing no OUT_VALID.
REQ-026 SHALL hold IN_READY low during reset and raise it the first cycle after RST deasserts.

Structure
REQ-027 SHALL place STATE_SIZE, Z_WIDTH, ROW_SIZE, PLANE_SIZE=320, the FSM state enum, and the 32-entry 5-bit CHI_INV_LUT in package sha3_pkg.
REQ-028 SHALL generate CHI_INV_LUT at elaboration by inverting the chi row function, not hand-typed.
REQ-029 SHALL instantiate 64 copies of sub-module chi_inv_row (5-bit in, 5-bit out, combinational LUT lookup), with inputs muxed from the selected plane.

Verification
REQ-030 SHALL check: reset, then IN all zeros -> OUT all zeros, OUT_VALID exactly 5 cycles after the handshake.
REQ-031 SHALL check: IN all ones -> OUT all ones.
REQ-032 SHALL check: IN with only bits 0 and 192 set -> OUT with only bit 0 set.
REQ-033 SHALL check: 1000 random states with OUT_READY randomly throttled -> chi(OUT)==IN per a reference model, and OUT stable while stalled.
REQ-034 SHALL check: RST pulsed at BUSY cycle 2 -> no OUT_VALID, IN_READY high the cycle after RST drops, and the next transaction is correct.
REQ-035 SHALL check: IN_VALID held high during BUSY/DONE with a different IN -> only the first state is processed.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared constants, FSM encoding and the inverse-chi row table for the chi_inv block.
package sha3_pkg;
  localparam int STATE_SIZE = 1600;
  localparam int Z_WIDTH    = 64;
  localparam int ROW_SIZE   = 5;
  localparam int PLANE_SIZE = ROW_SIZE * Z_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

  function automatic logic [4:0] chi_row(input logic [4:0] a);
    logic [4:0] b;
    for (int x = 0; x < 5; x++) b[x] = a[x] ^ (~a[(x + 1) % 5] & a[(x + 2) % 5]);
    return b;
  endfunction

  // chi is a bijection on 5 bits, so scattering a into slot chi(a) fills every entry.
  function automatic logic [31:0][4:0] gen_chi_inv_lut();
    logic [31:0][4:0] lut;
    lut = '0;
    for (int a = 0; a < 32; a++) lut[chi_row(5'(a))] = 5'(a);
    return lut;
  endfunction

  localparam logic [31:0][4:0] CHI_INV_LUT = gen_chi_inv_lut();
endpackage

// File: rtl/chi_inv_row.sv
// Combinational inverse chi for one 5-bit row (bit x of the vector is lane x).
module chi_inv_row
  import sha3_pkg::*;
(
  input  logic [4:0] i_row,
  output logic [4:0] o_row
);
  assign o_row = CHI_INV_LUT[i_row];
endmodule

// File: rtl/chi_inv.sv
// Iterative inverse of Keccak chi: one plane (64 rows) per cycle, five cycles per state.
module chi_inv #(
  parameter int STATE_SIZE = 1600,
  parameter int Z_WIDTH    = 64,
  parameter int ROW_SIZE   = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [0:STATE_SIZE-1] IN,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [0:STATE_SIZE-1] OUT,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY
);
  import sha3_pkg::*;

  localparam int PLANE_W = ROW_SIZE * Z_WIDTH;

  fsm_t                   r_fsm;
  logic [2:0]             r_cnt;
  logic [0:STATE_SIZE-1]  r_state;
  logic                   r_out_valid;

  logic [Z_WIDTH-1:0][ROW_SIZE-1:0] w_row_in;
  logic [Z_WIDTH-1:0][ROW_SIZE-1:0] w_row_out;
  logic [0:STATE_SIZE-1]            w_next;

  // Gather the selected plane into rows: row z, lane x lives at y*320 + x*64 + z.
  always_comb begin
    w_row_in = '0;
    for (int z = 0; z < Z_WIDTH; z++)
      for (int x = 0; x < ROW_SIZE; x++)
        w_row_in[z][x] = r_state[int'(r_cnt) * PLANE_W + x * Z_WIDTH + z];
  end

  for (genvar z = 0; z < Z_WIDTH; z++) begin : g_row
    chi_inv_row u_row (
      .i_row(w_row_in[z]),
      .o_row(w_row_out[z])
    );
  end

  always_comb begin
    w_next = r_state;
    for (int z = 0; z < Z_WIDTH; z++)
      for (int x = 0; x < ROW_SIZE; x++)
        w_next[int'(r_cnt) * PLANE_W + x * Z_WIDTH + z] = w_row_out[z][x];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_fsm       <= IDLE;
      r_cnt       <= 3'd0;
      r_state     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (IN_VALID) begin
            r_state <= IN;
            r_cnt   <= 3'd0;
            r_fsm   <= BUSY;
          end
        end
        BUSY: begin
          r_state <= w_next;
          if (r_cnt == 3'd4) begin
            r_fsm       <= DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        DONE: begin
          if (OUT_READY) begin
            r_fsm       <= IDLE;
            r_cnt       <= 3'd0;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_fsm       <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY  = (r_fsm == IDLE) && !RST;
  assign OUT       = r_state;
  assign OUT_VALID = r_out_valid;
endmodule

// File: tb/tb_chi_inv.sv
// Directed and randomised checks of chi_inv against a forward-chi reference.
module tb_chi_inv;
  localparam int N = 1600;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [0:N-1] IN = '0;
  logic         IN_VALID = 1'b0;
  logic         IN_READY;
  logic [0:N-1] OUT;
  logic         OUT_VALID;
  logic         OUT_READY = 1'b0;

  int total = 0;
  int bad   = 0;

  chi_inv dut (
    .CLK(CLK), .RST(RST), .IN(IN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT(OUT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [0:N-1] chi_ref(input logic [0:N-1] a);
    logic [0:N-1] b;
    b = '0;
    for (int y = 0; y < 5; y++)
      for (int z = 0; z < 64; z++)
        for (int x = 0; x < 5; x++)
          b[y*320 + x*64 + z] = a[y*320 + x*64 + z] ^
            (~a[y*320 + ((x+1)%5)*64 + z] & a[y*320 + ((x+2)%5)*64 + z]);
    return b;
  endfunction

  // Drive s until a handshake edge occurs; ok=0 if IN_READY never rose.
  task automatic send(input logic [0:N-1] s, output bit ok);
    int n;
    n = 0;
    IN = s;
    IN_VALID = 1'b1;
    while (!IN_READY && n < 50) begin @(posedge CLK); #1; n++; end
    ok = IN_READY;
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!OUT_VALID && cyc < 20) begin @(posedge CLK); #1; cyc++; end
  endtask

  task automatic accept();
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1 OUT_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", IN_READY); end
    total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", OUT_VALID); end
    total++; if (OUT !== '0) begin bad++; $display("FAIL reset_out got nonzero want=0"); end
    RST = 1'b0;
    #1;
    total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b want=1", IN_READY); end
  endtask

  task automatic test_zeros();
    bit ok; int cyc;
    logic [0:N-1] z;
    z = '0;
    send(z, ok);
    total++; if (!ok) begin bad++; $display("FAIL zeros_handshake got=timeout want=accept"); end
    wait_out(cyc);
    total++; if (cyc !== 5) begin bad++; $display("FAIL zeros_latency got=%0d want=5", cyc); end
    total++; if (OUT !== z) begin bad++; $display("FAIL zeros_out got=%h want=0", OUT); end
    accept();
    total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL zeros_drop_valid got=%b want=0", OUT_VALID); end
    total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL zeros_ready_after got=%b want=1", IN_READY); end
  endtask

  task automatic test_ones();
    bit ok; int cyc;
    logic [0:N-1] o;
    o = '1;
    send(o, ok);
    wait_out(cyc);
    total++; if (cyc !== 5) begin bad++; $display("FAIL ones_latency got=%0d want=5", cyc); end
    total++; if (OUT !== o) begin bad++; $display("FAIL ones_out got=%h want=all-ones", OUT); end
    accept();
  endtask

  task automatic test_single();
    bit ok; int cyc;
    logic [0:N-1] s, e;
    s = '0; s[0] = 1'b1; s[192] = 1'b1;
    e = '0; e[0] = 1'b1;
    send(s, ok);
    wait_out(cyc);
    total++; if (cyc !== 5) begin bad++; $display("FAIL single_latency got=%0d want=5", cyc); end
    total++; if (OUT !== e) begin bad++; $display("FAIL single_out got=%h want=%h", OUT, e); end
    accept();
  endtask

  task automatic test_ignore_input();
    bit ok; int cyc;
    logic [0:N-1] a, b, e;
    a = '0; a[0] = 1'b1; a[192] = 1'b1;
    e = '0; e[0] = 1'b1;
    b = '1;
    send(a, ok);
    IN = b;
    IN_VALID = 1'b1;
    wait_out(cyc);
    total++; if (cyc !== 5) begin bad++; $display("FAIL ignore_latency got=%0d want=5", cyc); end
    repeat (3) begin
      @(posedge CLK); #1;
      total++; if (OUT !== e || OUT_VALID !== 1'b1) begin bad++; $display("FAIL ignore_hold got=%h v=%b want=%h v=1", OUT, OUT_VALID, e); end
    end
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1 OUT_READY = 1'b0; IN_VALID = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL ignore_no_second got=%b want=0 at %0d", OUT_VALID, i); end
    end
  endtask

  task automatic test_reset_abort();
    bit ok; int cyc;
    logic [0:N-1] s;
    s = '1;
    send(s, ok);
    @(posedge CLK);
    @(posedge CLK);
    #1 RST = 1'b1;
    #1;
    total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL abort_ready_in_reset got=%b want=0", IN_READY); end
    @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL abort_ready_after got=%b want=1", IN_READY); end
    for (int i = 0; i < 10; i++) begin
      total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL abort_no_valid got=%b want=0 at %0d", OUT_VALID, i); end
      @(posedge CLK); #1;
    end
    for (int w = 0; w < N/32; w++) s[w*32 +: 32] = $urandom();
    send(s, ok);
    wait_out(cyc);
    total++; if (cyc !== 5) begin bad++; $display("FAIL abort_next_latency got=%0d want=5", cyc); end
    total++; if (chi_ref(OUT) !== s) begin bad++; $display("FAIL abort_next_chi got=%h want=%h", chi_ref(OUT), s); end
    accept();
  endtask

  task automatic test_random();
    bit ok; int cyc; int stall;
    logic [0:N-1] s, held;
    for (int t = 0; t < 1000; t++) begin
      for (int w = 0; w < N/32; w++) s[w*32 +: 32] = $urandom();
      send(s, ok);
      wait_out(cyc);
      total++; if (cyc !== 5) begin bad++; $display("FAIL rand_latency t=%0d got=%0d want=5", t, cyc); end
      held = OUT;
      stall = $urandom_range(0, 3);
      for (int k = 0; k < stall; k++) begin
        @(posedge CLK); #1;
        total++; if (OUT !== held || OUT_VALID !== 1'b1) begin bad++; $display("FAIL rand_stall t=%0d v=%b got=%h want=%h", t, OUT_VALID, OUT, held); end
      end
      total++; if (chi_ref(OUT) !== s) begin bad++; $display("FAIL rand_chi t=%0d got=%h want=%h", t, chi_ref(OUT), s); end
      accept();
    end
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_ones();
    test_single();
    test_random();
    test_reset_abort();
    test_ignore_input();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
